// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and helpers for the UART transmit arbiter.
//   state_e  : arbiter FSM states (IDLE waits for a request, GRANT owns the UART)
//   CNT_W    : width of the requester-stall watchdog counter
//   wrap_inc : index + 1 modulo n, used to start the round-robin scan
// -----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int CNT_W = 16;

    // Next index after idx, wrapping back to 0 at n.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set bit of req, scanning
// upward from index start and wrapping modulo N_REQ.
// Ports:
//   req   in  N_REQ : candidate request bits
//   start in  ID_W  : first index to examine (must be < N_REQ)
//   found out 1     : at least one request bit is set
//   idx   out ID_W  : index of the chosen request (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    // Scan N_REQ positions starting at start; the first hit wins.
    always_comb begin
        int          pos_int;
        logic [ID_W-1:0] pos;
        logic        take;
        found   = 1'b0;
        idx     = {ID_W{1'b0}};
        pos_int = 0;
        pos     = {ID_W{1'b0}};
        take    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_int = int'(start) + k;
            pos_int = (pos_int >= N_REQ) ? pos_int - N_REQ : pos_int;
            pos     = ID_W'(pos_int);
            take    = !found && req[pos];
            idx     = take ? pos : idx;
            found   = found | take;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, packet-locked arbiter sharing one UART TX byte port among N_REQ
// requesters. A grant is held from the first byte until the owner's last byte
// is accepted; a stall watchdog releases an owner that stops sending bytes.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_last    : per-requester byte valid / end-of-packet flag
//   req_data              : requester i at [i*DATA_W +: DATA_W]
//   req_ready             : per-requester accept (owner only, follows tx_ready)
//   tx_data/tx_valid      : byte stream to the UART TX core
//   tx_ready              : UART TX core can take a byte
//   grant                 : one-hot owner, zero when idle
//   busy                  : a requester owns the UART
//   timeout_err           : one-cycle pulse on a watchdog release
//   timeout_id            : owner index of the most recent watchdog release
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ   = 3,
    parameter  int DATA_W  = 8,
    parameter  int TIMEOUT = 1023,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [ID_W-1:0]         timeout_id
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [ID_W-1:0]    own_q, own_d;       // index form of grant_q
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [ID_W-1:0]    timeout_id_q, timeout_id_d;

    logic [ID_W-1:0]    start_s;
    logic               found_s;
    logic [ID_W-1:0]    pick_s;
    logic               xfer_s;

    assign start_s = ID_W'(wrap_inc(int'(last_id_q), N_REQ));

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (start_s),
        .found (found_s),
        .idx   (pick_s)
    );

    // Owner passthrough: byte path and ready only exist while granted;
    // tx_valid deliberately does not depend on tx_ready.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = {DATA_W{1'b0}};
        req_ready = {N_REQ{1'b0}};
        if (state_q == GRANT) begin
            tx_valid         = req_valid[own_q];
            tx_data          = req_data[int'(own_q)*DATA_W +: DATA_W];
            req_ready[own_q] = tx_ready;
        end else begin
            tx_valid  = 1'b0;
            tx_data   = {DATA_W{1'b0}};
            req_ready = {N_REQ{1'b0}};
        end
    end

    assign xfer_s      = tx_valid && tx_ready;
    assign grant       = grant_q;
    assign busy        = (state_q == GRANT);
    assign timeout_err = timeout_err_q;
    assign timeout_id  = timeout_id_q;

    // Next-state logic: arbitration, packet lock and stall watchdog.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_id_d     = last_id_q;
        own_d         = own_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        timeout_id_d  = timeout_id_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = GRANT;
                    grant_d = ONE_HOT0 << pick_s;
                    own_d   = pick_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (xfer_s) begin
                    // A transfer always beats an expiring watchdog.
                    if (req_last[own_q]) begin
                        state_d   = IDLE;
                        grant_d   = {N_REQ{1'b0}};
                        last_id_d = own_q;
                    end else begin
                        cnt_d = {CNT_W{1'b0}};
                    end
                end else if (!req_valid[own_q]) begin
                    // Requester stall; UART backpressure takes the hold path below.
                    if (cnt_q == CNT_LIMIT) begin
                        state_d       = IDLE;
                        grant_d       = {N_REQ{1'b0}};
                        last_id_d     = own_q;
                        timeout_err_d = 1'b1;
                        timeout_id_d  = own_q;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {N_REQ{1'b0}};
            end
        endcase
    end

    // State registers; last_id resets to N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= {N_REQ{1'b0}};
            last_id_q     <= ID_W'(N_REQ - 1);
            own_q         <= {ID_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            timeout_err_q <= 1'b0;
            timeout_id_q  <= {ID_W{1'b0}};
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_id_q     <= last_id_d;
            own_q         <= own_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=3, DATA_W=8, TIMEOUT=16).
// Requesters are modelled as byte queues; every queued byte is also pushed to
// a scoreboard in the expected service order and checked when it leaves on tx.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;
    logic [1:0]     timeout_id;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [2:0] mask;    // requesters loaded together
        int         n;       // number of packets
        logic [5:0] order;   // expected service order, 2 bits per slot, slot 0 low
    } vec_t;

    logic [8:0] src [N][$];  // {last, data} per requester
    exp_t       sb[$];
    int         xfer_cyc[$];
    logic [N-1:0] acc = '0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       to_allowed = 1'b0;
    exp_t       e;
    int         rr_exp[8] = '{0, 1, 3, 4, 6, 7, 9, 10};
    vec_t       vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue one packet of n bytes on requester id; term puts last on the final byte.
    task automatic pkt(input int id, input logic [7:0] base, input int n, input bit term);
        logic [7:0] b;
        exp_t x;
        for (int k = 0; k < n; k++) begin
            b = base + 8'(k);
            src[id].push_back({(term && (k == n - 1)), b});
            x.id   = id;
            x.data = b;
            sb.push_back(x);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, (k >= budget) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Requester model: retire accepted bytes, then present each queue head.
    always @(posedge clk) begin
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
        logic [N-1:0]   l;
        #2;
        for (int i = 0; i < N; i++)
            if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
        v = '0; d = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            if (src[i].size() > 0) begin
                v[i]       = 1'b1;
                d[i*W +: W] = src[i][0][7:0];
                l[i]       = src[i][0][8];
            end
        end
        req_valid = v;
        req_data  = d;
        req_last  = l;
    end

    // Monitor: scoreboard on every transfer plus per-cycle routing checks.
    always @(negedge clk) begin
        cyc++;
        acc = req_ready & req_valid;
        if (tx_valid && tx_ready) begin
            xfer_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("xfer_grant", grant, 32'd1 << e.id);
                chk("xfer_data", tx_data, e.data);
            end
        end
        if (busy) begin
            chk("ready_route", req_ready, tx_ready ? grant : 3'b000);
        end else begin
            chk("idle_tx_valid", tx_valid, 1'b0);
            chk("idle_ready", req_ready, 3'b000);
            chk("idle_grant", grant, 3'b000);
        end
        if (!to_allowed) chk("no_timeout", timeout_err, 1'b0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b010, 1, {2'd0, 2'd0, 2'd1}};
        vecs[1] = '{3'b101, 2, {2'd0, 2'd0, 2'd2}};
        vecs[2] = '{3'b111, 3, {2'd0, 2'd2, 2'd1}};
        vecs[3] = '{3'b110, 2, {2'd0, 2'd2, 2'd1}};
        vecs[4] = '{3'b011, 2, {2'd0, 2'd1, 2'd0}};
        vecs[5] = '{3'b100, 1, {2'd0, 2'd0, 2'd2}};
        vecs[6] = '{3'b001, 1, {2'd0, 2'd0, 2'd0}};

        reset = 1'b1; tx_ready = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        #3;
        chk("rst_grant", grant, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_to_err", timeout_err, 1'b0);
        chk("rst_to_id", timeout_id, 2'd0);
        step(2);
        reset = 1'b0;

        // Single request: 3 bytes back to back, idle after the last.
        step(1);
        pkt(0, 8'h41, 3, 1'b1);
        @(negedge clk);
        chk("arb_latency", busy, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("single_busy", busy, (k <= 3) ? 32'd1 : 32'd0);
            if (k == 1) chk("single_grant", grant, 3'b001);
        end
        drain("single_drain", 20);

        // Round robin 0,1,2 then 0 again with one bubble between packets.
        do_reset();
        xfer_cyc.delete();
        step(1);
        pkt(0, 8'h10, 2, 1'b1);
        pkt(1, 8'h12, 2, 1'b1);
        pkt(2, 8'h14, 2, 1'b1);
        pkt(0, 8'h16, 2, 1'b1);
        drain("rr_drain", 60);
        chk("rr_count", xfer_cyc.size(), 32'd8);
        if (xfer_cyc.size() == 8)
            for (int k = 1; k < 8; k++)
                chk("rr_spacing", xfer_cyc[k] - xfer_cyc[0], rr_exp[k]);

        // No interleave: req0 arrives while req1 is mid-packet.
        step(1);
        pkt(1, 8'h20, 4, 1'b1);
        step(2);
        pkt(0, 8'h30, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_interleave_ready0", req_ready[0], 1'b0);
            chk("no_interleave_grant", grant, 3'b010);
        end
        drain("ni_drain", 30);

        // UART backpressure for 5000 cycles never trips the watchdog.
        step(1);
        pkt(1, 8'h50, 3, 1'b1);
        step(2);
        tx_ready = 1'b0;
        repeat (5000) @(posedge clk);
        @(negedge clk);
        chk("bp_busy", busy, 1'b1);
        chk("bp_grant", grant, 3'b010);
        step(1);
        tx_ready = 1'b1;
        drain("bp_drain", 20);

        // Requester stall: req2 sends one non-last byte then goes quiet.
        step(1);
        to_allowed = 1'b1;
        pkt(2, 8'h70, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("to_grant", grant, 3'b100);
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            chk("to_early", timeout_err, 1'b0);
            if (k == 5) begin
                pkt(0, 8'h74, 2, 1'b1);
                pkt(1, 8'h78, 2, 1'b1);
            end
        end
        @(negedge clk);
        chk("to_pulse", timeout_err, 1'b1);
        chk("to_id", timeout_id, 2'd2);
        chk("to_idle", busy, 1'b0);
        @(negedge clk);
        chk("to_once", timeout_err, 1'b0);
        chk("to_next_grant", grant, 3'b001);
        chk("to_id_hold", timeout_id, 2'd2);
        to_allowed = 1'b0;
        drain("to_drain", 30);

        // Table of simultaneous single-byte requests from a known pointer.
        do_reset();
        for (int r = 0; r < 7; r++) begin
            step(1);
            for (int k = 0; k < vecs[r].n; k++) begin
                int id;
                id = int'(vecs[r].order[2*k +: 2]);
                chk("vec_mask", vecs[r].mask[id], 1'b1);
                pkt(id, 8'h80 + 8'(r * 8) + 8'(id), 1, 1'b1);
            end
            drain("vec_drain", 20);
        end

        // Reset in the middle of req1's packet.
        step(1);
        pkt(1, 8'hA0, 6, 1'b1);
        step(3);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_grant", grant, 3'b000);
        chk("rstmid_tx_valid", tx_valid, 1'b0);
        chk("rstmid_ready", req_ready, 3'b000);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_to_id", timeout_id, 2'd0);
        for (int i = 0; i < N; i++) src[i].delete();
        sb.delete();
        pkt(0, 8'hB0, 2, 1'b1);
        pkt(1, 8'hC0, 2, 1'b1);
        step(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_bubble", busy, 1'b0);
        @(negedge clk);
        chk("rstmid_first", grant, 3'b001);
        drain("rstmid_drain", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- **Purpose:** round-robin, packet-locked arbiter that shares the single `uart_basic` transmit byte interface among `N_REQ` on-chip requesters (for example the Nios II bridge, SPI sensor logger and IRQ event reporter).
- **Packet integrity:** a grant is held from the first byte until the requester's `last` byte is accepted, so packets never interleave on the serial line.
- **Stall recovery:** a stall watchdog frees the UART if the granted requester stops supplying bytes mid-packet.
- **Placement:** between the requesters' byte streams and the UART TX core's valid/ready port.

## Interface
- `N_REQ`, default 3: number of requesters; range 2..8.
- `DATA_W`, default 8: byte width.
- `TIMEOUT`, default 1023: requester-stall cycles before a forced release; range 1..65535.
- `ID_W`, default `$clog2(N_REQ)`: width of `timeout_id`; derived, not overridden.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `reset` in 1: reset is asynchronous and active-high.
- `req_valid` in `N_REQ`: per-requester byte valid.
- `req_data` in `N_REQ*DATA_W`: requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_last` in `N_REQ`: the offered byte ends the packet.
- `req_ready` out `N_REQ`: per-requester accept; at most one bit set.
- `tx_data` out `DATA_W`: byte to the UART TX core.
- `tx_valid` out 1: byte valid to the UART TX core.
- `tx_ready` in 1: UART TX core can accept a byte.
- `grant` out `N_REQ`: one-hot current owner; all zeros when idle.
- `busy` out 1: high in GRANT.
- `timeout_err` out 1: one-cycle pulse on a forced release.
- `timeout_id` out `ID_W`: index of the requester that timed out; holds until the next timeout.

## Operation
- **States:** IDLE and GRANT.
- **Registered state:** `state`, `grant`, `last_id` (round-robin pointer), stall counter `cnt` (16 bit).
- **IDLE:**
  - `tx_valid` = 0 and `req_ready` = 0.
  - If any `req_valid` is set, pick the first set bit scanning from `last_id+1`, wrapping modulo `N_REQ`.
  - Register the pick into `grant`, go to GRANT, clear `cnt`.
- **GRANT**, with owner g:
  - `tx_valid = req_valid[g]`, `tx_data = req_data[g]`, `req_ready[g] = tx_ready`; these are combinational passthroughs.
  - A transfer is a cycle with `tx_valid && tx_ready`.
- **Transfer with `req_last[g]`:** next state IDLE, `grant` ← 0, `last_id` ← g.
- **Transfer without last:** `cnt` ← 0.
- **No transfer and `req_valid[g]` = 0 (requester stall):** `cnt` increments. A UART backpressure stall (`req_valid[g]` = 1, `tx_ready` = 0) holds `cnt` and never times out.
- **Timeout:** stall cycle with `cnt == TIMEOUT-1`.
  - Next state IDLE, `grant` ← 0, `last_id` ← g.
  - `timeout_err` pulses for 1 cycle and `timeout_id` ← g.
- **Simultaneous events:**
  - A transfer on the cycle `cnt` would expire wins: no timeout.
  - Requests arriving while in GRANT wait; requester priority is purely round-robin.
- **Glitch tolerance:** a requester dropping `req_valid` after arbitration in IDLE still receives the grant and relies on the watchdog or a later byte.
- **Reset values, all asserted immediately:**
  - State IDLE, `grant` = 0, `last_id` = `N_REQ-1` (so requester 0 wins first), `cnt` = 0.
  - `tx_valid` = 0, `req_ready` = 0, `busy` = 0, `timeout_err` = 0, `timeout_id` = 0.
- **Reset mid-packet:** the partial packet is abandoned; there is no replay.

## Timing
- **Arbitration latency:** `req_valid` seen in IDLE at cycle n → `grant`/`busy` high at n+1; the first byte may transfer in cycle n+1.
- **Throughput:** one byte per cycle while granted; the rate is limited only by `tx_ready`.
- **Packet gap:** exactly one IDLE bubble cycle between consecutive packets, even from the same requester.
- **Combinational paths:** `req_valid`/`req_data` → `tx_valid`/`tx_data`, and `tx_ready` → `req_ready`. There is no combinational path from `tx_ready` to `tx_valid`.
- **Timeout timing:** `timeout_err` is high in the cycle after the expiring stall cycle, coincident with the return to IDLE.

## Structure
- **Package `uart_arb_pkg`:** state enum (IDLE, GRANT), `CNT_W` = 16, helper function for the wrapped index increment.
- **Sub-module `rr_pick`:** combinational; inputs `req[N_REQ]` and `start` index; outputs `found` and `idx`. The rest of the design is a single FSM, counter and output mux.

## Test plan
- **Single request:** req0 sends 3 bytes `0x41`, `0x42`, `0x43` with last on `0x43`, `tx_ready` = 1 → grant = `001` one cycle after valid; 3 consecutive transfers; IDLE on cycle 5.
- **Round-robin order:** req0, req1 and req2 all valid with 2-byte packets → serviced 0, 1, 2; then req0 again after req2, with one bubble between packets.
- **No interleave:** req1 holds grant while req0 asserts valid mid-packet → `req_ready[0]` stays 0 until req1's last byte is accepted.
- **Backpressure:** `tx_ready` = 0 for 5000 cycles mid-packet with `req_valid` = 1 → no timeout; the packet completes intact.
- **Timeout:** `TIMEOUT` = 16; req2 sends 1 non-last byte then drops valid → `timeout_err` pulses once 16 stall cycles after the byte, with `timeout_id` = 2; req0 is then granted next.
- **Reset mid-packet:** `reset` asserted during req1's packet → `grant`, `tx_valid` and `req_ready` drop immediately; after release, a pending req0 and req1 resolve to requester 0 first.
